// File: rtl/spw_flags_pkg.sv
// rtl/spw_flags_pkg.sv - register map, POP word layout and FSM states for spw_flags_event_ctrl
package spw_flags_pkg;

    // Avalon register addresses
    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_EDGE     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_POP      = 3'd5;

    // POP word: [31]=valid, flags sit directly above the timestamp
    localparam int POP_VALID_BIT  = 31;
    localparam int POP_TS_LSB     = 0;

    // STATUS word: [31]=sticky overflow, low bits = FIFO count
    localparam int STATUS_OVF_BIT = 31;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/spw_flags_evfifo.sv
// rtl/spw_flags_evfifo.sv - synchronous event FIFO with count and simultaneous push/pop at full
module spw_flags_evfifo #(
    parameter int DW    = 27,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          ovf_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_pop;
    logic          do_push;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot this cycle, so a push at full can still land
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign ovf_o   = push_i & full_o & ~do_pop;

    // Entry storage; contents are only observed while count is non-zero
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/spw_flags_event_ctrl.sv
// rtl/spw_flags_event_ctrl.sv - SpaceWire flag edge capture, irq and event log; SPW_FLAGS_GLITCH_FILTER_EN adds a glitch filter
module spw_flags_event_ctrl
    import spw_flags_pkg::*;
#(
    parameter int WIDTH         = 11,
    parameter int FIFO_DEPTH    = 8,
    parameter int TS_WIDTH      = 16,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port
);

    localparam int EW            = WIDTH + TS_WIDTH;
    localparam int CW            = $clog2(FIFO_DEPTH) + 1;
    localparam int POP_FLAGS_LSB = POP_TS_LSB + TS_WIDTH;

    logic [WIDTH-1:0]    meta_q;
    logic [WIDTH-1:0]    sync_q;
    logic [WIDTH-1:0]    flags_s;
    logic [WIDTH-1:0]    prev_q;
    logic [WIDTH-1:0]    edge_q;
    logic [WIDTH-1:0]    edge_d;
    logic [WIDTH-1:0]    mask_q;
    logic [WIDTH-1:0]    edge_sel_q;
    logic [WIDTH-1:0]    rise;
    logic [WIDTH-1:0]    fall;
    logic [WIDTH-1:0]    hit;
    state_t              state_q;
    logic [1:0]          prime_cnt_q;
    logic [TS_WIDTH-1:0] ts_q;
    logic                ovf_q;
    logic                ovf_d;
    logic [31:0]         readdata_q;
    logic [31:0]         rdata_d;
    logic                irq_q;
    logic                wr_en;
    logic                rd_en;
    logic                push;
    logic                pop_req;
    logic [EW-1:0]       fifo_dout;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                fifo_ovf;

    assign wr_en    = chipselect & write;
    assign rd_en    = chipselect & read;
    assign readdata = readdata_q;
    assign irq      = irq_q;

    // Two-flop synchroniser for the asynchronous codec flags
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= in_port;
            sync_q <= meta_q;
        end
    end

`ifdef SPW_FLAGS_GLITCH_FILTER_EN
    logic [WIDTH-1:0] filt_q;
    logic [7:0]       fcnt_q [WIDTH];

    // Accept a new level only after FILTER_CYCLES consecutive differing samples
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                fcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == 8'(FILTER_CYCLES - 1)) begin
                    filt_q[i] <= sync_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 8'd1;
                end
            end
        end
    end

    assign flags_s = filt_q;

    logic unused_cfg;
    assign unused_cfg = ^{writedata, fifo_full};
`else
    assign flags_s = sync_q;

    logic unused_cfg;
    assign unused_cfg = ^{writedata, fifo_full, 32'(FILTER_CYCLES)};
`endif

    // PRIME lets the synchroniser and prev settle for 3 cycles before events are logged
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PRIME;
            prime_cnt_q <= '0;
        end else begin
            case (state_q)
                PRIME: begin
                    prime_cnt_q <= prime_cnt_q + 2'd1;
                    if (prime_cnt_q == 2'd2) begin
                        state_q <= RUN;
                    end
                end
                RUN:     state_q <= RUN;
                default: state_q <= PRIME;
            endcase
        end
    end

    // Previous flag sample and free-running timestamp
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
            ts_q   <= '0;
        end else begin
            prev_q <= flags_s;
            ts_q   <= ts_q + 1'b1;
        end
    end

    // Edge detection and sticky-bit next state; a new hit beats a same-cycle W1C
    always_comb begin
        rise = flags_s & ~prev_q;
        fall = ~flags_s & prev_q;
        hit  = (state_q == RUN) ? (rise | (fall & edge_sel_q)) : '0;

        edge_d = edge_q;
        if (wr_en && address == ADDR_EDGE) begin
            edge_d = edge_q & ~writedata[WIDTH-1:0];
        end
        edge_d = edge_d | hit;

        ovf_d = ovf_q;
        if (wr_en && address == ADDR_STATUS && writedata[STATUS_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        ovf_d = ovf_d | fifo_ovf;

        push    = |hit;
        pop_req = rd_en && (address == ADDR_POP);
    end

    // Control registers and the registered interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            edge_q     <= '0;
            mask_q     <= '0;
            edge_sel_q <= '0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            edge_q <= edge_d;
            ovf_q  <= ovf_d;
            irq_q  <= |(edge_q & mask_q);
            if (wr_en && address == ADDR_IRQMASK) begin
                mask_q <= writedata[WIDTH-1:0];
            end
            if (wr_en && address == ADDR_EDGE_SEL) begin
                edge_sel_q <= writedata[WIDTH-1:0];
            end
        end
    end

    // Read-data multiplexer; unmapped bits and addresses return zero
    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_DATA:     rdata_d[WIDTH-1:0] = flags_s;
            ADDR_EDGE:     rdata_d[WIDTH-1:0] = edge_q;
            ADDR_IRQMASK:  rdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE_SEL: rdata_d[WIDTH-1:0] = edge_sel_q;
            ADDR_STATUS: begin
                rdata_d[CW-1:0]           = fifo_count;
                rdata_d[STATUS_OVF_BIT]   = ovf_q;
            end
            ADDR_POP: begin
                if (!fifo_empty) begin
                    rdata_d[POP_VALID_BIT]              = 1'b1;
                    rdata_d[POP_TS_LSB +: TS_WIDTH]     = fifo_dout[TS_WIDTH-1:0];
                    rdata_d[POP_FLAGS_LSB +: WIDTH]     = fifo_dout[EW-1:TS_WIDTH];
                end
            end
            default:       rdata_d = '0;
        endcase
    end

    // Read data is captured on the strobe and held until the next read
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (rd_en) begin
            readdata_q <= rdata_d;
        end
    end

    spw_flags_evfifo #(
        .DW    (EW),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_evfifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop_req),
        .din_i   ({flags_s, ts_q}),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .ovf_o   (fifo_ovf)
    );

endmodule

// File: tb/tb_spw_flags_event_ctrl.sv
// tb/tb_spw_flags_event_ctrl.sv - directed self-checking bench for spw_flags_event_ctrl
module tb_spw_flags_event_ctrl;
    import spw_flags_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [10:0] in_port;

    int total = 0;
    int bad   = 0;

    logic [31:0] d;
    logic [15:0] prev_ts;
    logic [15:0] ts_diff;

    always #5 clk = ~clk;

    spw_flags_event_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .in_port    (in_port)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] v);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = v;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] v);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        v = readdata;
    endtask

    task automatic pop_flags(input string tag, input logic [10:0] exp_flags);
        logic [31:0] v;
        bus_rd(ADDR_POP, v);
        check({tag, "_valid"}, {31'b0, v[31]}, 32'd1);
        check({tag, "_flags"}, (v >> 16) & 32'h7FF, {21'b0, exp_flags});
        prev_ts = v[15:0];
    endtask

    initial begin
        reset = 1'b1; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; in_port = 11'h7FF; prev_ts = '0;
        idle(3);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        idle(6);

`ifdef SPW_FLAGS_GLITCH_FILTER_EN
        in_port = 11'h000;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(10);
        bus_wr(ADDR_EDGE_SEL, 32'h7FF);
        bus_rd(ADDR_STATUS, d); check("flt_status0", d, 32'h0);
        in_port = 11'h010; idle(3); in_port = 11'h000; idle(12);
        bus_rd(ADDR_STATUS, d); check("flt_short_count", d, 32'h0);
        bus_rd(ADDR_EDGE, d);   check("flt_short_edge", d, 32'h0);
        in_port = 11'h010; idle(5); in_port = 11'h000; idle(12);
        bus_rd(ADDR_STATUS, d); check("flt_long_count", d, 32'h2);
        bus_rd(ADDR_EDGE, d);   check("flt_long_edge", d, 32'h010);
        pop_flags("flt_pop_rise", 11'h010);
        pop_flags("flt_pop_fall", 11'h000);
`else
        // Reset with all flags high: nothing logged during PRIME
        bus_rd(ADDR_EDGE, d);   check("prime_edge", d, 32'h0);
        bus_rd(ADDR_STATUS, d); check("prime_status", d, 32'h0);
        bus_rd(ADDR_DATA, d);   check("prime_data", d, 32'h7FF);
        bus_wr(ADDR_DATA, 32'h0);
        bus_rd(ADDR_DATA, d);   check("data_ro", d, 32'h7FF);
        bus_rd(3'd6, d);        check("addr6_zero", d, 32'h0);

        // Falling edges ignored with EDGE_SEL=0
        in_port = 11'h000; idle(6);
        bus_rd(ADDR_EDGE, d);   check("fall_ignored_edge", d, 32'h0);
        bus_rd(ADDR_STATUS, d); check("fall_ignored_count", d, 32'h0);

        // Rising bit0 with mask bit0
        bus_wr(ADDR_IRQMASK, 32'h1);
        in_port = 11'h001; idle(6);
        check("irq_set", {31'b0, irq}, 32'h1);
        bus_rd(ADDR_EDGE, d);   check("edge_bit0", d, 32'h001);
        bus_rd(ADDR_STATUS, d); check("count_one", d, 32'h1);
        pop_flags("pop_bit0", 11'h001);
        bus_rd(ADDR_STATUS, d); check("count_zero_after_pop", d, 32'h0);
        bus_wr(ADDR_EDGE, 32'h1);
        idle(1);
        check("irq_clear", {31'b0, irq}, 32'h0);
        bus_rd(ADDR_EDGE, d);   check("edge_w1c", d, 32'h0);

        // Both edges on bit2: 2-cycle low pulse logs fall then rise, 2 cycles apart
        bus_wr(ADDR_EDGE_SEL, 32'h4);
        in_port = 11'h005; idle(6);
        bus_wr(ADDR_EDGE, 32'h7FF);
        pop_flags("pop_bit2_up", 11'h005);
        in_port = 11'h001; idle(2); in_port = 11'h005; idle(6);
        bus_rd(ADDR_EDGE, d);   check("edge_bit2_both", d, 32'h004);
        bus_rd(ADDR_STATUS, d); check("count_both", d, 32'h2);
        pop_flags("pop_fall", 11'h001);
        d = {16'b0, prev_ts};
        pop_flags("pop_rise", 11'h005);
        ts_diff = prev_ts - d[15:0];
        check("pulse_ts_step", {16'b0, ts_diff}, 32'd2);

        // Rising only: same pulse logs one event
        bus_wr(ADDR_EDGE_SEL, 32'h0);
        bus_wr(ADDR_EDGE, 32'h7FF);
        in_port = 11'h001; idle(2); in_port = 11'h005; idle(6);
        bus_rd(ADDR_EDGE, d);   check("edge_bit2_rise", d, 32'h004);
        bus_rd(ADDR_STATUS, d); check("count_rise_only", d, 32'h1);
        pop_flags("pop_rise_only", 11'h005);

        // Nine toggles of bit3 four cycles apart into an 8-deep FIFO
        bus_wr(ADDR_EDGE_SEL, 32'h8);
        for (int i = 0; i < 9; i++) begin
            in_port = in_port ^ 11'h008; idle(4);
        end
        idle(6);
        bus_rd(ADDR_STATUS, d); check("ovf_status", d, 32'h8000_0008);
        for (int i = 0; i < 8; i++) begin
            d = {16'b0, prev_ts};
            pop_flags($sformatf("ovf_pop%0d", i), (i % 2 == 0) ? 11'h00D : 11'h005);
            if (i > 0) begin
                ts_diff = prev_ts - d[15:0];
                check($sformatf("ovf_ts_step%0d", i), {16'b0, ts_diff}, 32'd4);
            end
        end
        bus_rd(ADDR_POP, d);    check("pop_empty", d, 32'h0);
        bus_rd(ADDR_STATUS, d); check("ovf_sticky", d, 32'h8000_0000);
        bus_wr(ADDR_STATUS, 32'h8000_0000);
        bus_rd(ADDR_STATUS, d); check("ovf_w1c", d, 32'h0);

        // Refill to full, then push and pop in the same cycle
        for (int i = 0; i < 8; i++) begin
            in_port = in_port ^ 11'h008; idle(4);
        end
        idle(6);
        bus_rd(ADDR_STATUS, d); check("full_count", d, 32'h8);
        in_port = in_port ^ 11'h008; idle(2);
        bus_rd(ADDR_POP, d);
        check("full_pushpop_valid", {31'b0, d[31]}, 32'h1);
        check("full_pushpop_flags", (d >> 16) & 32'h7FF, 32'h005);
        idle(2);
        bus_rd(ADDR_STATUS, d); check("full_pushpop_status", d, 32'h8);

        // W1C on EDGE in the same cycle as a new hit on that bit
        bus_wr(ADDR_EDGE, 32'h7FF);
        in_port = in_port ^ 11'h008; idle(2);
        bus_wr(ADDR_EDGE, 32'h8);
        idle(1);
        bus_rd(ADDR_EDGE, d);   check("w1c_vs_set", d, 32'h008);

        // Drain, then push and pop together on an empty FIFO
        for (int i = 0; i < 8; i++) begin
            bus_rd(ADDR_POP, d);
        end
        bus_rd(ADDR_STATUS, d); check("drained", d, 32'h8000_0000);
        in_port = in_port ^ 11'h008; idle(2);
        bus_rd(ADDR_POP, d);    check("empty_pushpop", d, 32'h0);
        idle(2);
        bus_rd(ADDR_STATUS, d); check("empty_pushpop_status", d, 32'h8000_0001);
        pop_flags("empty_pushpop_entry", in_port);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spw_flags_event_ctrl.md
Name: spw_flags_event_ctrl

Overview:
Avalon-MM slave controller for the SpaceWire link-status flag vector (11 bits: link state, errors, credit and tick indicators).
- Synchronises the flags and detects per-bit edges.
- Keeps sticky, maskable edge-capture bits and drives a level interrupt.
- Logs every flag change, with a timestamp, into a small event FIFO that the CPU drains.
- Sits between the SpaceWire codec status outputs and the Nios/Avalon interconnect; replaces plain polling of the raw flag port.

Parameters:
- WIDTH, 11, number of flag bits.
- FIFO_DEPTH, 8, event FIFO entries; power of two, 2..64.
- TS_WIDTH, 16, free-running timestamp width; WIDTH+TS_WIDTH <= 31.
- FILTER_CYCLES, 4, stability window for the optional glitch filter; range 2..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  register select.
- chipselect  in  1  slave select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.
- in_port  in  WIDTH  asynchronous flag inputs.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high; everything updates on posedge clk.
- Reset values: readdata=0, irq=0, all registers=0, FIFO empty, timestamp=0, FSM=PRIME.
- Synchroniser: 2-flop per bit; sync output flags_s; prev holds the last flags_s.
- FSM PRIME -> RUN:
  - PRIME lasts 3 cycles after reset deassertion, with a 2-bit counter.
  - prev tracks flags_s; no events are generated.
  - Then RUN. Reset asserted in any state returns to PRIME and clears all state.
- Edge detect in RUN: rise = flags_s & ~prev; fall = ~flags_s & prev; hit = rise | (fall & EDGE_SEL).
- Timestamp: TS_WIDTH-bit counter, +1 every cycle, wraps to 0.
- Register map (address):
  - 0 DATA RO: flags_s.
  - 1 EDGE W1C: sticky hit bits. Same-cycle set and clear: set wins.
  - 2 IRQMASK RW.
  - 3 EDGE_SEL RW: 0 = rising only, 1 = both edges.
  - 4 STATUS: [7:0]=count RO; [31]=overflow, sticky, W1C.
  - 5 POP RO: [31]=valid, [WIDTH+TS_WIDTH-1:TS_WIDTH]=flags, [TS_WIDTH-1:0]=timestamp; remaining bits 0.
  - 6, 7: read 0, writes ignored.
- Reads: readdata is valid 1 cycle after chipselect&read, and holds until the next read. Unmapped bits read 0.
- FIFO push: any |hit pushes {flags_s, timestamp} of that cycle.
- FIFO pop: a read of POP pops the head. Empty FIFO returns 0 (valid=0) and has no side effect.
- Full FIFO: push is dropped and overflow is set. Push and pop in the same cycle at full: both happen, count unchanged, no overflow. Same cycle at empty: push only; the read returns valid=0.
- irq = |(EDGE & IRQMASK), registered; asserts 1 cycle after the EDGE update.
- Writes to RO registers are ignored.

Optional Feature:
- Macro: SPW_FLAGS_GLITCH_FILTER_EN.
- Defined: a per-bit counter sits between the synchroniser and edge detect. A new level is accepted only after FILTER_CYCLES consecutive equal samples, so pulses shorter than that produce no event. Latency from in_port to event becomes 2+FILTER_CYCLES cycles.
- Undefined: no filter; latency is 2 cycles (synchroniser) plus the detect cycle.

Decomposition:
- Package spw_flags_pkg holds:
  - register address constants (ADDR_DATA..ADDR_POP);
  - the POP entry bit-position constants;
  - the FSM state enum {PRIME, RUN}.
- One sub-module, spw_flags_evfifo: synchronous FIFO with count, full/empty and the push/pop-at-full rule. The top level holds the sync/filter, edge logic, registers and bus decode.

Test Plan:
- Reset with in_port=11'h7FF held high -> no EDGE bits, FIFO count 0 after PRIME; DATA reads 0x7FF.
- EDGE_SEL=0, IRQMASK=0x001; bit0 0->1 -> EDGE=0x001, irq=1, count=1, POP valid=1 with flags 0x001. Write EDGE=0x001 -> irq=0 next cycle.
- EDGE_SEL=0x004; bit2 pulses 1->0 -> EDGE bit2 set; EDGE_SEL=0 with the same pulse -> only the rising edge is logged.
- 9 distinct changes with FIFO_DEPTH=8 and no pops -> count=8, STATUS[31]=1; 8 pops return timestamps in increasing order (mod 2^16); the 9th pop returns 0.
- Push at full in the same cycle as a POP read -> count stays 8, overflow stays 0. W1C on EDGE in the same cycle as a new hit on that bit -> bit remains 1.
- With SPW_FLAGS_GLITCH_FILTER_EN, FILTER_CYCLES=4: a 3-cycle pulse -> no event; a 5-cycle pulse -> exactly 2 events (rise and fall, EDGE_SEL=1).
